hex_display_scanner: RTL

HEX_DISPLAY_SCANNER -- requirements
Module: hex_display_scanner

---
 rtl/display_pkg.sv | 31 +++
 rtl/hex_to_seg.sv | 12 +
 rtl/hex_display_scanner.sv | 117 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed hex display: default parameters and
// the active-low seven-segment code table (bit order a b c d e f g, a = MSB).
package display_pkg;

  localparam int DEF_NUM_DIGITS  = 8;
  localparam int DEF_REFRESH_DIV = 5000;
  localparam int DEF_BRIGHT_W    = 3;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entry n is the pattern for hex digit n; listed from F down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble-to-segment decoder; a blanked digit turns a..g off.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_OFF : SEG_TABLE[nibble_i];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex display driver with shadowed load, leading-zero
// blanking and PWM brightness; all outputs are registered.
module hex_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int BRIGHT_W    = DEF_BRIGHT_W
)(
  input  logic                    clock,
  input  logic                    rstn,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic [7:0]              segment,
  output logic                    scan_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dots_q;
  logic                    blz_q;
  logic                    wrap_q;
  logic                    scan_done_q;
  logic [NUM_DIGITS-1:0]   digit_q, digit_d;
  logic [7:0]              segment_q, segment_d;

  logic                    tc_wrap;
  logic [31:0]             on_lim;
  logic                    lit;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    run_zero;
  logic                    blank;
  logic [6:0]              seg7;

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  assign tc_wrap = (pre_q == PRE_LAST) && (idx_q == IDX_LAST);

  // On-time of each slot scales with brightness; full code gives the whole slot.
  assign on_lim = ((32'(brightness) + 32'd1) * 32'(REFRESH_DIV)) >> BRIGHT_W;
  assign lit    = 32'(pre_q) < on_lim;

  // lz[i] is set when nibble i and every more-significant nibble are zero.
  always_comb begin
    lz       = '0;
    run_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero = run_zero && (val_q[4*i +: 4] == 4'h0);
      lz[i]    = run_zero;
    end
  end

  assign cur_nib = val_q[{idx_q, 2'b00} +: 4];
  assign blank   = blz_q && (idx_q != '0) && lz[idx_q];

  hex_to_seg u_hex_to_seg (
    .nibble_i (cur_nib),
    .blank_i  (blank),
    .seg_o    (seg7)
  );

  always_comb begin
    digit_d = '1;
    if (lit) digit_d[idx_q] = 1'b0;
    segment_d = {seg7, ~dots_q[idx_q]};
  end

  // scan_done is delayed one extra cycle so it lines up with digit 0 on the outputs.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      pre_q       <= '0;
      idx_q       <= '0;
      val_q       <= '0;
      dots_q      <= '0;
      blz_q       <= 1'b0;
      wrap_q      <= 1'b0;
      scan_done_q <= 1'b0;
      digit_q     <= '1;
      segment_q   <= 8'hFF;
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      if (load) begin
        val_q  <= value;
        dots_q <= dots;
        blz_q  <= blank_lz;
      end
      wrap_q      <= tc_wrap;
      scan_done_q <= wrap_q;
      digit_q     <= digit_d;
      segment_q   <= segment_d;
    end
  end

  assign digit     = digit_q;
  assign segment   = segment_q;
  assign scan_done = scan_done_q;

endmodule
